// File: rtl/apb_arb2.sv
`default_nettype none
// ============================================================================
// Module   : apb_arb2
// Brief    : Two-master round-robin APB arbiter replaying transfers on one
//            slave bus. Define APB_ARB_TIMEOUT_EN for the ACCESS timeout abort.
// Revision : 1.0 - initial release
// ============================================================================
module apb_arb2 #(
  parameter int            AW       = 16,
  parameter int            DW       = 32,
  parameter int            TIMEOUT  = 256,
  parameter logic [DW-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic          clk,
  input  logic          rst,
  // master 0 (jtag2apb bridge)
  input  logic          m0_psel,
  input  logic          m0_penable,
  input  logic          m0_pwrite,
  input  logic [AW-1:0] m0_paddr,
  input  logic [DW-1:0] m0_pwdata,
  output logic [DW-1:0] m0_prdata,
  output logic          m0_pready,
  // master 1 (on-chip controller)
  input  logic          m1_psel,
  input  logic          m1_penable,
  input  logic          m1_pwrite,
  input  logic [AW-1:0] m1_paddr,
  input  logic [DW-1:0] m1_pwdata,
  output logic [DW-1:0] m1_prdata,
  output logic          m1_pready,
  // slave side
  output logic          s_psel,
  output logic          s_penable,
  output logic          s_pwrite,
  output logic [AW-1:0] s_paddr,
  output logic [DW-1:0] s_pwdata,
  input  logic [DW-1:0] s_prdata,
  input  logic          s_pready,
  output logic          tmo
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_grant;
  logic          r_last_grant;
  logic          w_win;
  logic          w_start;
  logic          w_finish;
  logic          w_abort;
  logic          w_tmo_hit;
  logic [DW-1:0] w_rdata;
  logic          w_unused;

  // penable only qualifies the master's own phase; arbitration keys off psel
  assign w_unused = ^{m0_penable, m1_penable, (TIMEOUT > 0)};

`ifdef APB_ARB_TIMEOUT_EN
  localparam int c_CW = $clog2(TIMEOUT + 1);
  logic [c_CW-1:0] r_tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_ACCESS)) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // count holds k during the (k+1)-th ACCESS cycle
  assign w_tmo_hit = (r_tmo_cnt == c_CW'(TIMEOUT - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    w_abort     = 1'b0;
    w_win       = (m0_psel && m1_psel) ? ~r_last_grant : m1_psel;
    case (r_state)
      ST_IDLE: begin
        if (m0_psel || m1_psel) begin
          w_start     = 1'b1;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (s_pready) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (w_tmo_hit) begin
          w_finish    = 1'b1;
          w_abort     = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_rdata = w_abort ? ERR_DATA : s_prdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      s_psel       <= 1'b0;
      s_penable    <= 1'b0;
      s_pwrite     <= 1'b0;
      s_paddr      <= '0;
      s_pwdata     <= '0;
      m0_prdata    <= '0;
      m1_prdata    <= '0;
      m0_pready    <= 1'b0;
      m1_pready    <= 1'b0;
      tmo          <= 1'b0;
    end else begin
      m0_pready <= 1'b0;
      m1_pready <= 1'b0;
      tmo       <= 1'b0;
      if (w_start) begin
        r_grant      <= w_win;
        r_last_grant <= w_win;
        s_psel       <= 1'b1;
        s_pwrite     <= w_win ? m1_pwrite : m0_pwrite;
        s_paddr      <= w_win ? m1_paddr  : m0_paddr;
        s_pwdata     <= w_win ? m1_pwdata : m0_pwdata;
      end
      if (r_state == ST_SETUP) begin
        s_penable <= 1'b1;
      end
      if (w_finish) begin
        s_psel    <= 1'b0;
        s_penable <= 1'b0;
        tmo       <= w_abort;
        if (r_grant) begin
          m1_prdata <= w_rdata;
          m1_pready <= 1'b1;
        end else begin
          m0_prdata <= w_rdata;
          m0_pready <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_arb2.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_arb2
// Brief    : Self-checking bench for apb_arb2 (vector table, corner sequences,
//            randomized traffic against a transaction-timeline model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_arb2;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int TMO  = 16;
  localparam int NRND = 3000;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_psel, m0_penable, m0_pwrite, m0_pready;
  logic [AW-1:0] m0_paddr;
  logic [DW-1:0] m0_pwdata, m0_prdata;
  logic          m1_psel, m1_penable, m1_pwrite, m1_pready;
  logic [AW-1:0] m1_paddr;
  logic [DW-1:0] m1_pwdata, m1_prdata;
  logic          s_psel, s_penable, s_pwrite, s_pready, tmo;
  logic [AW-1:0] s_paddr;
  logic [DW-1:0] s_pwdata, s_prdata;

  always #5 clk = ~clk;

  apb_arb2 #(.AW(AW), .DW(DW), .TIMEOUT(TMO), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst(rst),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
    .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_prdata(m0_prdata), .m0_pready(m0_pready),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
    .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_prdata(m1_prdata), .m1_pready(m1_pready),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite), .s_paddr(s_paddr),
    .s_pwdata(s_pwdata), .s_prdata(s_prdata), .s_pready(s_pready), .tmo(tmo)
  );

  typedef struct {
    bit          r0;
    bit          r1;
    int          wt;
    logic [31:0] rd;
    int          first;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int sl_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // slave answering after wt wait cycles once it sees the ACCESS phase
  task automatic slave_step(input int wt, input logic [31:0] rd);
    if (s_psel && s_penable) begin
      if (sl_cnt >= wt) begin
        s_pready = 1'b1;
        s_prdata = rd;
      end else begin
        s_pready = 1'b0;
        s_prdata = $urandom;
        sl_cnt++;
      end
    end else begin
      s_pready = 1'b0;
      s_prdata = $urandom;
      sl_cnt   = 0;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          seen;
    int          need;
    int          first_cyc;
    int          k;
    logic [31:0] other_before;
    tick();
    slave_step(v.wt, v.rd);
    other_before = v.r0 ? m1_prdata : m0_prdata;
    m0_psel = v.r0; m0_penable = v.r0; m0_pwrite = 1'b1;
    m0_paddr = 16'h0010; m0_pwdata = 32'h12345678;
    m1_psel = v.r1; m1_penable = v.r1; m1_pwrite = 1'b0;
    m1_paddr = 16'h0004; m1_pwdata = 32'h0;
    need = int'(v.r0) + int'(v.r1);
    seen = 0;
    first_cyc = 0;
    for (int cyc = 1; cyc <= 60 && seen < need; cyc++) begin
      tick();
      if (m0_pready && m1_pready) chk($sformatf("v%0d dual pready", idx), 1, 0);
      if (m0_pready || m1_pready) begin
        k = m1_pready ? 1 : 0;
        if (seen == 0) begin
          chk($sformatf("v%0d first grant", idx), k, v.first);
          chk($sformatf("v%0d latency", idx), cyc, 3 + v.wt);
          first_cyc = cyc;
        end else begin
          chk($sformatf("v%0d second grant", idx), k, 1 - v.first);
          chk($sformatf("v%0d second gap", idx), cyc - first_cyc, 4 + v.wt);
        end
        chk($sformatf("v%0d prdata", idx), k ? m1_prdata : m0_prdata, v.rd);
        if (k == 1) m1_psel = 1'b0; else m0_psel = 1'b0;
        seen++;
      end
      slave_step(v.wt, v.rd);
    end
    if (seen < need) chk($sformatf("v%0d completions before bound", idx), seen, need);
    if (need == 1)
      chk($sformatf("v%0d other prdata held", idx), v.r0 ? m1_prdata : m0_prdata, other_before);
    m0_psel = 1'b0; m1_psel = 1'b0; m0_penable = 1'b0; m1_penable = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[9];
    int          early;
    // random-phase model: transaction timeline per granted transfer
    bit          rq[2];
    logic [AW-1:0] ra[2];
    logic [DW-1:0] rw[2];
    bit          rwr[2];
    logic [DW-1:0] exp_prd[2];
    bit          active;
    int          cur, last, t_sel, t_rdy, t_done, wsel;
    bit          in_sel, in_acc;

    vecs[0] = '{1'b1, 1'b1, 0, 32'hA1A1A1A1, 0};
    vecs[1] = '{1'b1, 1'b1, 2, 32'hB2B2B2B2, 0};
    vecs[2] = '{1'b1, 1'b0, 0, 32'h00000011, 0};
    vecs[3] = '{1'b0, 1'b1, 5, 32'hCAFEF00D, 1};
    vecs[4] = '{1'b0, 1'b1, 1, 32'h44440004, 1};
    vecs[5] = '{1'b1, 1'b1, 0, 32'h55555555, 0};
    vecs[6] = '{1'b1, 1'b0, 3, 32'h66660006, 0};
    vecs[7] = '{1'b1, 1'b1, 1, 32'h77777777, 1};
    vecs[8] = '{1'b1, 1'b1, 0, 32'h88888888, 1};

    rst = 1'b1;
    m0_psel = 0; m0_penable = 0; m0_pwrite = 0; m0_paddr = '0; m0_pwdata = '0;
    m1_psel = 0; m1_penable = 0; m1_pwrite = 0; m1_paddr = '0; m1_pwdata = '0;
    s_pready = 0; s_prdata = '0;
    tick(); tick(); tick();
    chk("reset s_psel", s_psel, 0);
    chk("reset s_penable", s_penable, 0);
    chk("reset s_paddr", s_paddr, 0);
    chk("reset pready", {m0_pready, m1_pready}, 0);
    chk("reset prdata", m0_prdata | m1_prdata, 0);
    chk("reset tmo", tmo, 0);
    rst = 1'b0;

    // single m0 write, slave ready tied high
    tick();
    m0_psel = 1; m0_penable = 1; m0_pwrite = 1; m0_paddr = 16'h0010; m0_pwdata = 32'h12345678;
    s_pready = 1; s_prdata = 32'h0;
    tick();
    chk("t1 s_psel N+1", s_psel, 1);
    chk("t1 s_penable N+1", s_penable, 0);
    chk("t1 s_paddr", s_paddr, 16'h0010);
    chk("t1 s_pwrite", s_pwrite, 1);
    chk("t1 s_pwdata", s_pwdata, 32'h12345678);
    tick();
    chk("t1 s_penable N+2", s_penable, 1);
    chk("t1 m0_pready N+2", m0_pready, 0);
    tick();
    chk("t1 m0_pready N+3", m0_pready, 1);
    chk("t1 m1_pready", m1_pready, 0);
    chk("t1 s_psel dropped", s_psel, 0);
    m0_psel = 0; m0_penable = 0; s_pready = 0;
    tick();
    chk("t1 pready width", m0_pready, 0);

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    foreach (vecs[i]) run_vec(vecs[i], i);

    // reset during ACCESS, then tie goes back to m0
    tick();
    s_pready = 0;
    m1_psel = 1; m1_penable = 1; m1_pwrite = 0; m1_paddr = 16'h0004;
    tick(); tick();
    chk("t4 in access", s_penable, 1);
    rst = 1'b1;
    tick();
    chk("t4 rst s_psel", s_psel, 0);
    chk("t4 rst s_penable", s_penable, 0);
    chk("t4 rst pready", {m0_pready, m1_pready}, 0);
    chk("t4 rst prdata", m0_prdata | m1_prdata, 0);
    rst = 1'b0;
    m0_psel = 1; m0_penable = 1; m0_pwrite = 0; m0_paddr = 16'h0008;
    s_pready = 1; s_prdata = 32'h5A5A0001;
    tick(); tick();
    chk("t4 no early pready", {m0_pready, m1_pready}, 0);
    tick();
    chk("t4 m0 served first", {m0_pready, m1_pready}, 2'b10);
    chk("t4 m0 prdata", m0_prdata, 32'h5A5A0001);
    m0_psel = 0; m1_psel = 0; m0_penable = 0; m1_penable = 0; s_pready = 0;
    tick();

    // stalled slave: abort with the timeout build, endless wait otherwise
    tick();
    m0_psel = 1; m0_penable = 1; m0_pwrite = 0; m0_paddr = 16'h0020; s_pready = 0;
    early = 0;
    for (int i = 1; i <= TMO + 1; i++) begin
      tick();
      if (m0_pready || m1_pready || tmo) early++;
    end
    chk("t5 no early pready/tmo", early, 0);
    tick();
`ifdef APB_ARB_TIMEOUT_EN
    chk("t5 abort pready", m0_pready, 1);
    chk("t5 abort prdata", m0_prdata, 32'hDEADBEEF);
    chk("t5 tmo pulse", tmo, 1);
    chk("t5 s_psel dropped", s_psel, 0);
    m0_psel = 0; m0_penable = 0;
    tick();
    chk("t5 tmo width", tmo, 0);
`else
    chk("t5 still waiting", m0_pready, 0);
    chk("t5 still in access", s_penable, 1);
    chk("t5 tmo low", tmo, 0);
    s_pready = 1; s_prdata = 32'h600D600D;
    tick();
    chk("t5 late completion", m0_pready, 1);
    chk("t5 late prdata", m0_prdata, 32'h600D600D);
    m0_psel = 0; m0_penable = 0; s_pready = 0;
    tick();
`endif

    // randomized traffic
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    m0_psel = 0; m1_psel = 0; s_pready = 0;
    for (int k = 0; k < 2; k++) begin
      rq[k] = 0; ra[k] = '0; rw[k] = '0; rwr[k] = 0; exp_prd[k] = '0;
    end
    active = 0; cur = 0; last = 1; t_sel = -10; t_rdy = -10; t_done = -1;
    for (int c = 0; c < NRND; c++) begin
      tick();
      in_sel = active && (c >= t_sel + 1) && (t_done < 0 || c < t_done);
      in_acc = active && (c >= t_sel + 2) && (t_done < 0 || c < t_done);
      chk($sformatf("rnd c%0d s_psel", c), s_psel, in_sel);
      chk($sformatf("rnd c%0d s_penable", c), s_penable, in_acc);
      chk($sformatf("rnd c%0d m0_pready", c), m0_pready, active && c == t_done && cur == 0);
      chk($sformatf("rnd c%0d m1_pready", c), m1_pready, active && c == t_done && cur == 1);
      chk($sformatf("rnd c%0d m0_prdata", c), m0_prdata, exp_prd[0]);
      chk($sformatf("rnd c%0d m1_prdata", c), m1_prdata, exp_prd[1]);
      chk($sformatf("rnd c%0d tmo", c), tmo, 0);
      if (in_sel) begin
        chk($sformatf("rnd c%0d s_paddr", c), s_paddr, ra[cur]);
        chk($sformatf("rnd c%0d s_pwrite", c), s_pwrite, rwr[cur]);
        chk($sformatf("rnd c%0d s_pwdata", c), s_pwdata, rw[cur]);
      end
      if (active && c == t_done) rq[cur] = 0;
      if (active && t_done >= 0 && c >= t_done + 1) active = 0;
      for (int k = 0; k < 2; k++) begin
        if (!rq[k] && $urandom_range(0, 2) == 0) begin
          rq[k] = 1; ra[k] = AW'($urandom); rw[k] = $urandom; rwr[k] = 1'($urandom);
        end
      end
      if (!active && (rq[0] || rq[1])) begin
        cur = (rq[0] && rq[1]) ? 1 - last : (rq[1] ? 1 : 0);
        last = cur; active = 1; t_sel = c; t_done = -1;
        wsel = $urandom_range(0, 4);
        t_rdy = c + 2 + wsel;
      end
      if (active && t_done < 0 && c == t_rdy) begin
        s_pready = 1; s_prdata = $urandom;
        exp_prd[cur] = s_prdata; t_done = c + 1;
      end else if (active && t_done < 0 && c >= t_sel + 2) begin
        s_pready = 0; s_prdata = $urandom;
      end else begin
        s_pready = 1'($urandom); s_prdata = $urandom;
      end
      m0_psel = rq[0]; m0_penable = 1'($urandom); m0_pwrite = rwr[0]; m0_paddr = ra[0];
      m0_pwdata = rw[0];
      m1_psel = rq[1]; m1_penable = 1'($urandom); m1_pwrite = rwr[1]; m1_paddr = ra[1];
      m1_pwdata = rw[1];
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
